if_stage: RTL and testbench

//  Instruction-fetch stage of the 5-stage RV32 pipeline; producer side of the IF->ID handshake.

---
 rtl/if_stage_if.sv | 22 ++
 rtl/if_stage.sv | 149 ++++++++++++++
 tb/tb_if_stage.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// IF->ID handshake bundle: the fetch stage presents {inst,pc} plus an exception
// code, and decode answers with ds_allowin.
interface if_stage_if;
  logic        fs_to_ds_valid;
  logic        ds_allowin;
  logic [63:0] if_id_bus_out;
  logic [5:0]  exception_code_fd;

  modport master (
    output fs_to_ds_valid,
    output if_id_bus_out,
    output exception_code_fd,
    input  ds_allowin
  );

  modport slave (
    input  fs_to_ds_valid,
    input  if_id_bus_out,
    input  exception_code_fd,
    output ds_allowin
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage of the 5-stage RV32 pipeline.
// Drives a 1-cycle synchronous instruction memory and buffers each returned
// {inst,pc} in a small FIFO that feeds decode. A fetch is only issued when
// the FIFO is guaranteed a free slot for its return (credit rule), so the
// buffer can never overflow. Branch/jump and trap/mret redirects flush the
// buffer and drop any read still in flight.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INST   = 32'h0000_0033
) (
  input  logic              clk,
  input  logic              rst_n,
  if_stage_if.master        ds,
  input  logic              br_jmp_flag,
  input  logic [31:0]       br_target,
  input  logic              trap_flag,
  input  logic [31:0]       trap_pc,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic [31:0]       imem_rdata
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W:0]   OCC_LIMIT = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [5:0]       EXC_MISALIGNED = 6'b100000;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [5:0]  exc;
  } fetch_entry_t;

  // Fetch-side state
  logic [31:0] pc_r;
  logic        inflight;
  logic [31:0] inflight_pc;
  logic        run_r;

  // Fetch buffer
  fetch_entry_t     fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic         redirect;
  logic [31:0]  target;
  logic         fifo_empty;
  logic         pop;
  logic         push;
  logic         issue;
  logic [CNT_W:0] occupancy;
  fetch_entry_t push_entry;
  fetch_entry_t head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Trap/mret outranks a simultaneous branch from EXE.
  assign redirect = trap_flag | br_jmp_flag;
  assign target   = trap_flag ? trap_pc : br_target;

  assign fifo_empty        = (count == '0);
  assign ds.fs_to_ds_valid = !fifo_empty && !redirect;
  assign pop               = ds.fs_to_ds_valid && ds.ds_allowin;

  // Slots already spoken for: buffered entries plus the read still returning.
  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};

  // A pop this cycle frees a slot in time for the return next cycle.
  // run_r holds off the very first request until the cycle after reset.
  assign issue     = run_r && !redirect && ((occupancy < OCC_LIMIT) || pop);
  assign imem_req  = issue;
  assign imem_addr = {pc_r[31:2], 2'b00};

  assign push = inflight && !redirect;

  // Build the entry for the returning read; misaligned PCs become a NOP carrying an exception.
  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    push_entry.inst = imem_rdata;
    push_entry.pc   = inflight_pc;
    push_entry.exc  = '0;
    if (inflight_pc[1:0] != 2'b00) begin
      push_entry.inst = NOP_INST;
      push_entry.exc  = EXC_MISALIGNED;
    end
  end

  // Decode sees all-zero payload whenever the buffer is empty.
  assign head                 = fifo_mem[rd_ptr];
  assign ds.if_id_bus_out     = fifo_empty ? 64'd0 : {head.inst, head.pc};
  assign ds.exception_code_fd = fifo_empty ? 6'd0  : head.exc;

  // PC generation and in-flight read tracking; a redirect restarts fetch at the target.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r        <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      run_r       <= 1'b0;
    end else begin
      run_r <= 1'b1;
      if (redirect) begin
        pc_r     <= target;
        inflight <= 1'b0;
      end else if (issue) begin
        inflight    <= 1'b1;
        inflight_pc <= pc_r;
        pc_r        <= pc_r + 32'd4;
      end else begin
        inflight <= 1'b0;
      end
    end
  end

  // Buffer pointers and occupancy; a redirect empties the buffer outright.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Buffer storage write port.
  // NOTE: the storage array has no reset; entries are only observed once count says they were written.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_entry;
  end

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed stimulus, a queue-based reference model
// checked every cycle, and hand-computed literal expectations.
module tb_if_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0033;
  localparam int          DEPTH    = 2;

  logic        clk;
  logic        rst_n;
  logic        br_jmp_flag;
  logic [31:0] br_target;
  logic        trap_flag;
  logic [31:0] trap_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;

  if_stage_if ds_bus ();

  if_stage #(
    .RESET_PC  (RESET_PC),
    .FIFO_DEPTH(DEPTH),
    .NOP_INST  (NOP_INST)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ds         (ds_bus.master),
    .br_jmp_flag(br_jmp_flag),
    .br_target  (br_target),
    .trap_flag  (trap_flag),
    .trap_pc    (trap_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: word at address a reads back as ~a, one cycle later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)        imem_rdata <= 32'd0;
    else if (imem_req) imem_rdata <= ~imem_addr;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [5:0]  exc;
  } exp_t;

  exp_t        m_q [$];
  logic [31:0] m_pc   = RESET_PC;
  logic        m_infl = 1'b0;
  logic [31:0] m_ipc  = 32'd0;
  logic        m_run  = 1'b0;
  logic [31:0] del_q [$];

  function automatic exp_t fetch_result(input logic [31:0] pc);
    exp_t e;
    e.pc = pc;
    if (pc[1:0] != 2'b00) begin
      e.inst = NOP_INST;
      e.exc  = 6'b100000;
    end else begin
      e.inst = ~pc;
      e.exc  = 6'd0;
    end
    return e;
  endfunction

  // Compare DUT outputs against the model mid-cycle, then advance the model.
  always @(negedge clk) begin : cmp
    logic        m_redirect;
    logic [31:0] m_target;
    logic        m_valid;
    logic        m_pop;
    logic        m_req;
    if (!rst_n) begin
      check("rst_req",   {63'd0, imem_req}, 64'd0);
      check("rst_valid", {63'd0, ds_bus.fs_to_ds_valid}, 64'd0);
      check("rst_bus",   ds_bus.if_id_bus_out, 64'd0);
      check("rst_exc",   {58'd0, ds_bus.exception_code_fd}, 64'd0);
      m_q.delete();
      m_pc   = RESET_PC;
      m_infl = 1'b0;
      m_run  = 1'b0;
    end else begin
      m_redirect = trap_flag | br_jmp_flag;
      m_target   = trap_flag ? trap_pc : br_target;
      m_valid    = (m_q.size() != 0) && !m_redirect;
      m_pop      = m_valid && ds_bus.ds_allowin;
      m_req      = m_run && !m_redirect && (((m_q.size() + int'(m_infl)) < DEPTH) || m_pop);

      check("mdl_req",   {63'd0, imem_req}, {63'd0, m_req});
      check("mdl_valid", {63'd0, ds_bus.fs_to_ds_valid}, {63'd0, m_valid});
      if (m_req) check("mdl_addr", {32'd0, imem_addr}, {32'd0, m_pc[31:2], 2'b00});
      if (m_q.size() == 0) begin
        check("mdl_bus_empty", ds_bus.if_id_bus_out, 64'd0);
        check("mdl_exc_empty", {58'd0, ds_bus.exception_code_fd}, 64'd0);
      end else begin
        check("mdl_bus", ds_bus.if_id_bus_out, {m_q[0].inst, m_q[0].pc});
        check("mdl_exc", {58'd0, ds_bus.exception_code_fd}, {58'd0, m_q[0].exc});
      end

      if (ds_bus.fs_to_ds_valid && ds_bus.ds_allowin) del_q.push_back(ds_bus.if_id_bus_out[31:0]);

      if (m_redirect) begin
        m_q.delete();
        m_infl = 1'b0;
        m_pc   = m_target;
      end else begin
        if (m_pop)  void'(m_q.pop_front());
        if (m_infl) m_q.push_back(fetch_result(m_ipc));
        if (m_req) begin
          m_infl = 1'b1;
          m_ipc  = m_pc;
          m_pc   = m_pc + 32'd4;
        end else begin
          m_infl = 1'b0;
        end
      end
      m_run = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle redirect, then literal checks on the refetch.
  task automatic redirect(input logic tf, input logic [31:0] tp,
                          input logic bf, input logic [31:0] bt,
                          input logic [31:0] exp_addr, input logic [31:0] exp_pc,
                          input logic [31:0] exp_inst, input logic [5:0] exp_exc);
    cyc();
    trap_flag = tf; trap_pc = tp; br_jmp_flag = bf; br_target = bt;
    #1;
    check("redir_valid_low", {63'd0, ds_bus.fs_to_ds_valid}, 64'd0);
    check("redir_req_low",   {63'd0, imem_req}, 64'd0);
    cyc();
    trap_flag = 1'b0; br_jmp_flag = 1'b0;
    #1;
    check("redir_req",  {63'd0, imem_req}, 64'd1);
    check("redir_addr", {32'd0, imem_addr}, {32'd0, exp_addr});
    cyc();
    cyc();
    #1;
    check("redir_tgt_valid", {63'd0, ds_bus.fs_to_ds_valid}, 64'd1);
    check("redir_tgt_bus",   ds_bus.if_id_bus_out, {exp_inst, exp_pc});
    check("redir_tgt_exc",   {58'd0, ds_bus.exception_code_fd}, {58'd0, exp_exc});
  endtask

  logic [63:0] held;
  logic [15:0] pat;
  int          n_300;

  initial begin
    rst_n = 1'b0;
    ds_bus.ds_allowin = 1'b1;
    br_jmp_flag = 1'b0; br_target = 32'd0;
    trap_flag = 1'b0;   trap_pc = 32'd0;
    pat = 16'b1011_0010_1110_0101;

    repeat (3) cyc();
    #1;
    check("reset_req",   {63'd0, imem_req}, 64'd0);
    check("reset_valid", {63'd0, ds_bus.fs_to_ds_valid}, 64'd0);
    check("reset_bus",   ds_bus.if_id_bus_out, 64'd0);

    // Reset release: first request the following cycle, addresses 0,4,...
    cyc(); rst_n = 1'b1; #1;
    check("first_cycle_no_req", {63'd0, imem_req}, 64'd0);
    cyc(); #1;
    check("fetch0_req",  {63'd0, imem_req}, 64'd1);
    check("fetch0_addr", {32'd0, imem_addr}, 64'h0);
    cyc(); #1;
    check("fetch1_addr", {32'd0, imem_addr}, 64'h4);
    cyc(); #1;
    check("deliver0_valid", {63'd0, ds_bus.fs_to_ds_valid}, 64'd1);
    check("deliver0_bus",   ds_bus.if_id_bus_out, {32'hFFFF_FFFF, 32'h0000_0000});
    cyc(); #1;
    check("deliver1_bus",   ds_bus.if_id_bus_out, {32'hFFFF_FFFB, 32'h0000_0004});
    repeat (3) cyc();

    // Decode stall for 5 cycles: buffer fills, requests stop, head holds.
    cyc(); ds_bus.ds_allowin = 1'b0; #1;
    held = ds_bus.if_id_bus_out;
    repeat (5) cyc();
    #1;
    check("stall_head_held", ds_bus.if_id_bus_out, held);
    check("stall_req_off",   {63'd0, imem_req}, 64'd0);
    check("stall_valid",     {63'd0, ds_bus.fs_to_ds_valid}, 64'd1);
    cyc(); ds_bus.ds_allowin = 1'b1;
    repeat (4) cyc();

    // Branch to 0x100.
    redirect(1'b0, 32'h0, 1'b1, 32'h100, 32'h100, 32'h100, 32'hFFFF_FEFF, 6'd0);
    repeat (3) cyc();
    // Trap and branch together: trap wins.
    redirect(1'b1, 32'h200, 1'b1, 32'h100, 32'h200, 32'h200, 32'hFFFF_FDFF, 6'd0);
    repeat (3) cyc();
    // Misaligned branch target.
    redirect(1'b0, 32'h0, 1'b1, 32'h102, 32'h100, 32'h102, 32'h0000_0033, 6'b100000);
    repeat (2) cyc();

    // Back-to-back redirects: branch 0x300 then trap 0x400; the later one wins.
    cyc(); br_jmp_flag = 1'b1; br_target = 32'h300;
    cyc(); br_jmp_flag = 1'b0; trap_flag = 1'b1; trap_pc = 32'h400; #1;
    check("b2b_req_low", {63'd0, imem_req}, 64'd0);
    cyc(); trap_flag = 1'b0; #1;
    check("b2b_addr", {32'd0, imem_addr}, 64'h400);
    cyc();
    cyc(); #1;
    check("b2b_bus", ds_bus.if_id_bus_out, {32'hFFFF_FBFF, 32'h0000_0400});

    // Irregular decode back-pressure.
    for (int i = 0; i < 32; i++) begin
      cyc();
      ds_bus.ds_allowin = pat[i % 16];
    end

    // Fill the buffer, then pulse reset.
    cyc(); ds_bus.ds_allowin = 1'b0;
    repeat (4) cyc();
    #1;
    check("full_valid", {63'd0, ds_bus.fs_to_ds_valid}, 64'd1);
    cyc(); rst_n = 1'b0; #1;
    check("async_rst_valid", {63'd0, ds_bus.fs_to_ds_valid}, 64'd0);
    check("async_rst_bus",   ds_bus.if_id_bus_out, 64'd0);
    check("async_rst_exc",   {58'd0, ds_bus.exception_code_fd}, 64'd0);
    check("async_rst_req",   {63'd0, imem_req}, 64'd0);
    cyc();
    cyc(); rst_n = 1'b1; ds_bus.ds_allowin = 1'b1; #1;
    check("rerst_no_req", {63'd0, imem_req}, 64'd0);
    cyc(); #1;
    check("rerst_req",  {63'd0, imem_req}, 64'd1);
    check("rerst_addr", {32'd0, imem_addr}, {32'd0, RESET_PC});
    repeat (6) cyc();

    // Delivered stream: each PC follows its predecessor by 4 unless it is a redirect target.
    check("deliver_count_enough", {63'd0, del_q.size() > 40}, 64'd1);
    n_300 = 0;
    for (int i = 0; i < del_q.size(); i++) begin
      if (del_q[i] == 32'h300) n_300++;
      if (i > 0) begin
        check("deliver_order",
              {63'd0, (del_q[i] == del_q[i-1] + 32'd4) || (del_q[i] == 32'h0) ||
                      (del_q[i] == 32'h100) || (del_q[i] == 32'h200) ||
                      (del_q[i] == 32'h102) || (del_q[i] == 32'h400)},
              64'd1);
      end
    end
    check("overridden_target_absent", 64'(n_300), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
